bp_nonsynth_mem_responder: RTL and testbench



---
 rtl/bp_nonsynth_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_bp_nonsynth_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_nonsynth_mem_responder.sv
// bp_nonsynth_mem_responder
// Memory-side responder for the CCE-MEM interface, used only in simulation to
// stand in for DRAM/L2. It takes one single-beat command at a time, does the
// array access when the command is accepted, and returns one response after
// latency_p idle cycles.
// Optional feature: define BP_NONSYNTH_MEM_RESPONDER_ERR_EN to add a sticky
// err_o output. It flags unsupported message types and addresses beyond the
// array range.
module bp_nonsynth_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16,
    parameter int els_p           = 1024,
    parameter int latency_p       = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_and_o,
    input  logic [3:0]                 mem_cmd_msg_type_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,

    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_ready_and_i,
    output logic [3:0]                 mem_resp_msg_type_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
    ,
    output logic                       err_o
`endif
);

    localparam int bytes_lp     = block_width_p / 8;
    localparam int lg_bytes_lp  = $clog2(bytes_lp);
    localparam int lg_els_lp    = $clog2(els_p);
    localparam int cnt_width_lp = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

    typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

    state_e state, state_n;

    // Backing store. It is deliberately left out of reset, so data written
    // before a reset is still there after it.
    logic [block_width_p-1:0] mem [els_p];

    logic                     accept;
    logic                     is_rd;
    logic                     is_wr;
    logic [lg_els_lp-1:0]     line_idx;
    logic [lg_bytes_lp-1:0]   byte_off;
    logic [lg_bytes_lp-1:0]   size_mask;
    logic [lg_bytes_lp-1:0]   aligned_off;
    logic [lg_bytes_lp-1:0]   src_byte;
    logic [block_width_p-1:0] line;
    logic [block_width_p-1:0] rd_data;
    logic [block_width_p-1:0] wr_line;
    logic [cnt_width_lp-1:0]  cnt;

    // Upper address bits above the array range are dropped, so lines wrap
    // modulo els_p.
    assign line_idx = mem_cmd_addr_i[lg_bytes_lp +: lg_els_lp];
    assign byte_off = mem_cmd_addr_i[lg_bytes_lp-1:0];
    assign accept   = mem_cmd_v_i & mem_cmd_ready_and_o;

    // Decode the message type and turn the size into a byte mask capped at one line.
    always_comb begin
        is_rd = (mem_cmd_msg_type_i == 4'd0) || (mem_cmd_msg_type_i == 4'd2);
        is_wr = (mem_cmd_msg_type_i == 4'd1) || (mem_cmd_msg_type_i == 4'd3);
        if (int'(mem_cmd_size_i) >= lg_bytes_lp) begin
            size_mask = '1;
        end else begin
            size_mask = lg_bytes_lp'((1 << mem_cmd_size_i) - 1);
        end
        aligned_off = byte_off & ~size_mask;
    end

    // Per-byte lane steering. A read output byte i comes from the aligned
    // window at (i mod transfer bytes), which replicates the window across the
    // line. A write updates only the bytes inside the window, taking them from
    // the low bytes of the command data.
    always_comb begin
        line     = mem[line_idx];
        rd_data  = '0;
        wr_line  = line;
        src_byte = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            src_byte = aligned_off | (lg_bytes_lp'(i) & size_mask);
            rd_data[i*8 +: 8] = line[int'(src_byte)*8 +: 8];
            if ((lg_bytes_lp'(i) & ~size_mask) == aligned_off) begin
                wr_line[i*8 +: 8] = mem_cmd_data_i[int'(lg_bytes_lp'(i) & size_mask)*8 +: 8];
            end
        end
    end

    // Array write happens at the accept edge, so a later read sees it.
    always_ff @(posedge clk_i) begin
        if (accept && is_wr) begin
            mem[line_idx] <= wr_line;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= e_ready;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. The wait state runs until the counter is already zero,
    // so valid rises latency_p+1 edges after accept. A latency of zero skips
    // the wait state altogether.
    always_comb begin
        state_n = state;
        case (state)
            e_ready: if (accept) state_n = (latency_p == 0) ? e_resp : e_wait;
            e_wait:  if (cnt == '0) state_n = e_resp;
            e_resp:  if (mem_resp_ready_and_i) state_n = e_ready;
            default: state_n = e_ready;
        endcase
    end

    // Handshake outputs. Ready is gated by reset so it is low while reset is held.
    always_comb begin
        mem_cmd_ready_and_o = reset_n_i && (state == e_ready);
        mem_resp_v_o        = (state == e_resp);
    end

    // Latch the response header, the read data and the latency counter at accept.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_resp_msg_type_o <= '0;
            mem_resp_addr_o     <= '0;
            mem_resp_size_o     <= '0;
            mem_resp_payload_o  <= '0;
            mem_resp_data_o     <= '0;
            cnt                 <= '0;
        end else if (accept) begin
            mem_resp_msg_type_o <= mem_cmd_msg_type_i;
            mem_resp_addr_o     <= mem_cmd_addr_i;
            mem_resp_size_o     <= mem_cmd_size_i;
            mem_resp_payload_o  <= mem_cmd_payload_i;
            mem_resp_data_o     <= is_rd ? rd_data : '0;
            cnt                 <= cnt_width_lp'(latency_p);
        end else if ((state == e_wait) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
    logic bad_type;
    logic bad_addr;

    assign bad_type = !(is_rd || is_wr);
    assign bad_addr = (mem_cmd_addr_i >> (lg_bytes_lp + lg_els_lp)) != '0;

    // Sticky error flag for unsupported types or out-of-range addresses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o <= 1'b0;
        end else if (accept && (bad_type || bad_addr)) begin
            err_o <= 1'b1;
            $error("bp_nonsynth_mem_responder: bad command addr=%h type=%0d",
                   mem_cmd_addr_i, mem_cmd_msg_type_i);
        end
    end
`endif

endmodule

// File: tb/tb_bp_nonsynth_mem_responder.sv
// Directed testbench for bp_nonsynth_mem_responder. One instance uses
// latency_p=4 and a second uses latency_p=0. Define
// BP_NONSYNTH_MEM_RESPONDER_ERR_EN to also check err_o.
module tb_bp_nonsynth_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;

    logic         cmd_v, cmd_ready;
    logic [3:0]   cmd_type;
    logic [39:0]  cmd_addr;
    logic [2:0]   cmd_size;
    logic [15:0]  cmd_payload;
    logic [511:0] cmd_data;
    logic         resp_v, resp_ready;
    logic [3:0]   resp_type;
    logic [39:0]  resp_addr;
    logic [2:0]   resp_size;
    logic [15:0]  resp_payload;
    logic [511:0] resp_data;

    logic         cmd_v0, cmd_ready0;
    logic [3:0]   cmd_type0;
    logic [39:0]  cmd_addr0;
    logic [2:0]   cmd_size0;
    logic [15:0]  cmd_payload0;
    logic [511:0] cmd_data0;
    logic         resp_v0, resp_ready0;
    logic [3:0]   resp_type0;
    logic [39:0]  resp_addr0;
    logic [2:0]   resp_size0;
    logic [15:0]  resp_payload0;
    logic [511:0] resp_data0;
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
    logic         err, err0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    bp_nonsynth_mem_responder #(.latency_p(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .mem_cmd_v_i(cmd_v), .mem_cmd_ready_and_o(cmd_ready),
        .mem_cmd_msg_type_i(cmd_type), .mem_cmd_addr_i(cmd_addr),
        .mem_cmd_size_i(cmd_size), .mem_cmd_payload_i(cmd_payload),
        .mem_cmd_data_i(cmd_data),
        .mem_resp_v_o(resp_v), .mem_resp_ready_and_i(resp_ready),
        .mem_resp_msg_type_o(resp_type), .mem_resp_addr_o(resp_addr),
        .mem_resp_size_o(resp_size), .mem_resp_payload_o(resp_payload),
        .mem_resp_data_o(resp_data)
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
        , .err_o(err)
`endif
    );

    bp_nonsynth_mem_responder #(.latency_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n),
        .mem_cmd_v_i(cmd_v0), .mem_cmd_ready_and_o(cmd_ready0),
        .mem_cmd_msg_type_i(cmd_type0), .mem_cmd_addr_i(cmd_addr0),
        .mem_cmd_size_i(cmd_size0), .mem_cmd_payload_i(cmd_payload0),
        .mem_cmd_data_i(cmd_data0),
        .mem_resp_v_o(resp_v0), .mem_resp_ready_and_i(resp_ready0),
        .mem_resp_msg_type_o(resp_type0), .mem_resp_addr_o(resp_addr0),
        .mem_resp_size_o(resp_size0), .mem_resp_payload_o(resp_payload0),
        .mem_resp_data_o(resp_data0)
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
        , .err_o(err0)
`endif
    );

    task automatic checkOutput(input string tag, input logic [511:0] actual,
                               input logic [511:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Present one command at a negedge and drop valid just after the accept edge.
    task automatic applyStimulus(input logic [3:0] t, input logic [39:0] a,
                                 input logic [2:0] s, input logic [511:0] d,
                                 input logic [15:0] p);
        @(negedge clk);
        cmd_v = 1'b1; cmd_type = t; cmd_addr = a; cmd_size = s;
        cmd_data = d; cmd_payload = p;
        checkOutput("cmd_ready", 512'(cmd_ready), 512'(1));
        @(posedge clk);
        #1 cmd_v = 1'b0;
    endtask

    // Count edges after accept until resp_v is seen, bounded.
    task automatic waitResp(input string tag, input int exp_lat);
        int cycles = 0;
        bit ready_low = 1'b1;
        @(negedge clk);
        while (resp_v !== 1'b1 && cycles < 40) begin
            if (cmd_ready !== 1'b0) ready_low = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (cmd_ready !== 1'b0) ready_low = 1'b0;
        checkOutput({tag, "_lat"}, 512'(cycles), 512'(exp_lat));
        checkOutput({tag, "_ready_low"}, 512'(ready_low), 512'(1));
    endtask

    task automatic checkResp(input string tag, input logic [3:0] t, input logic [39:0] a,
                             input logic [2:0] s, input logic [15:0] p,
                             input logic [511:0] d);
        checkOutput({tag, "_type"}, 512'(resp_type), 512'(t));
        checkOutput({tag, "_addr"}, 512'(resp_addr), 512'(a));
        checkOutput({tag, "_size"}, 512'(resp_size), 512'(s));
        checkOutput({tag, "_payload"}, 512'(resp_payload), 512'(p));
        checkOutput({tag, "_data"}, resp_data, d);
    endtask

    // Full transaction with response ready held high.
    task automatic doTxn(input string tag, input logic [3:0] t, input logic [39:0] a,
                         input logic [2:0] s, input logic [511:0] d,
                         input logic [15:0] p, input logic [511:0] exp_data);
        applyStimulus(t, a, s, d, p);
        waitResp(tag, 5);
        checkResp(tag, t, a, s, p, exp_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] pat;
        logic [511:0] exp;
        bit stable;
        bit no_accept;
        bit no_resp;
        int accepts;

        reset_n = 1'b0;
        cmd_v = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_size = '0;
        cmd_payload = '0; cmd_data = '0; resp_ready = 1'b1;
        cmd_v0 = 1'b0; cmd_type0 = '0; cmd_addr0 = '0; cmd_size0 = '0;
        cmd_payload0 = '0; cmd_data0 = '0; resp_ready0 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 512'(cmd_ready), 512'(0));
        checkOutput("rst_resp_v", 512'(resp_v), 512'(0));
        checkOutput("rst_resp_data", resp_data, 512'(0));
        checkOutput("rst_resp_addr", 512'(resp_addr), 512'(0));
        checkOutput("rst_ready0", 512'(cmd_ready0), 512'(0));
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
        checkOutput("rst_err", 512'(err), 512'(0));
`endif
        reset_n = 1'b1;

        // Basic write/read and byte merge
        doTxn("wr80", 4'd1, 40'h80, 3'd3, 512'(64'h1122334455667788), 16'h0A1, 512'(0));
        doTxn("rd80", 4'd0, 40'h80, 3'd3, 512'(0), 16'h0A2, {8{64'h1122334455667788}});
        doTxn("ucwr83", 4'd3, 40'h83, 3'd0, 512'(8'hAB), 16'h0A3, 512'(0));
        doTxn("ucrd80", 4'd2, 40'h80, 3'd3, 512'(0), 16'h0A4, {8{64'h11223344AB667788}});

        // Full-line write, size capped read, aligned sub-word read
        for (int j = 0; j < 64; j++) pat[j*8 +: 8] = 8'(j);
        doTxn("wrline", 4'd1, 40'h1000, 3'd6, pat, 16'h0A5, 512'(0));
        doTxn("rdcap", 4'd0, 40'h1000, 3'd7, 512'(0), 16'h0A6, pat);
        doTxn("rdalign", 4'd0, 40'h1005, 3'd2, 512'(0), 16'h0A7, {16{32'h07060504}});

        // Unsupported type: header echoed, data zero, no array access
        doTxn("unsup", 4'd5, 40'h80, 3'd3, 512'(64'hFFFF_FFFF_FFFF_FFFF), 16'h0A8, 512'(0));
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
        checkOutput("err_set", 512'(err), 512'(1));
`endif
        doTxn("rd_after_unsup", 4'd0, 40'h80, 3'd3, 512'(0), 16'h0A9, {8{64'h11223344AB667788}});

        // Upper address bits wrap onto line 2
        doTxn("wrap", 4'd0, 40'h10080, 3'd3, 512'(0), 16'h0AA, {8{64'h11223344AB667788}});
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
        checkOutput("err_sticky", 512'(err), 512'(1));
`endif

        // Response backpressure: fields stable, no new accept
        resp_ready = 1'b0;
        exp = {16{32'h11223344}};
        applyStimulus(4'd0, 40'h84, 3'd2, 512'(0), 16'h0B1);
        waitResp("stall", 5);
        checkResp("stall", 4'd0, 40'h84, 3'd2, 16'h0B1, exp);
        stable = 1'b1; no_accept = 1'b1;
        cmd_v = 1'b1; cmd_addr = 40'h0; cmd_type = 4'd0;
        repeat (10) begin
            @(negedge clk);
            if (resp_v !== 1'b1 || resp_data !== exp || resp_addr !== 40'h84 ||
                resp_payload !== 16'h0B1 || resp_type !== 4'd0 || resp_size !== 3'd2)
                stable = 1'b0;
            if (cmd_ready !== 1'b0) no_accept = 1'b0;
        end
        checkOutput("stall_stable", 512'(stable), 512'(1));
        checkOutput("stall_no_accept", 512'(no_accept), 512'(1));
        cmd_v = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Zero-latency instance
        @(negedge clk);
        cmd_v0 = 1'b1; cmd_type0 = 4'd1; cmd_addr0 = 40'h40; cmd_size0 = 3'd3;
        cmd_data0 = 512'(64'h0123456789ABCDEF); cmd_payload0 = 16'h0C0;
        checkOutput("l0_ready", 512'(cmd_ready0), 512'(1));
        @(posedge clk);
        #1 cmd_type0 = 4'd0;
        @(negedge clk);
        checkOutput("l0_wr_resp_v", 512'(resp_v0), 512'(1));
        checkOutput("l0_wr_ready", 512'(cmd_ready0), 512'(0));
        checkOutput("l0_wr_data", resp_data0, 512'(0));
        checkOutput("l0_wr_type", 512'(resp_type0), 512'(1));
        @(negedge clk);
        checkOutput("l0_idle_resp_v", 512'(resp_v0), 512'(0));
        checkOutput("l0_idle_ready", 512'(cmd_ready0), 512'(1));
        @(negedge clk);
        checkOutput("l0_rd_resp_v", 512'(resp_v0), 512'(1));
        checkOutput("l0_rd_data", resp_data0, {8{64'h0123456789ABCDEF}});
        checkOutput("l0_rd_type", 512'(resp_type0), 512'(0));
        accepts = 0;
        repeat (8) begin
            @(negedge clk);
            if (cmd_v0 && cmd_ready0) accepts++;
        end
        checkOutput("l0_accept_rate", 512'(accepts), 512'(4));
        cmd_v0 = 1'b0;

        // Asynchronous reset during the wait state
        applyStimulus(4'd1, 40'h100, 3'd3, 512'(64'hDEADBEEFCAFEF00D), 16'h0C1);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_resp_v", 512'(resp_v), 512'(0));
        checkOutput("arst_ready", 512'(cmd_ready), 512'(0));
        checkOutput("arst_resp_addr", 512'(resp_addr), 512'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        no_resp = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (resp_v !== 1'b0) no_resp = 1'b0;
        end
        checkOutput("arst_no_resp", 512'(no_resp), 512'(1));
        checkOutput("arst_ready_after", 512'(cmd_ready), 512'(1));
`ifdef BP_NONSYNTH_MEM_RESPONDER_ERR_EN
        checkOutput("err_cleared", 512'(err), 512'(0));
`endif
        doTxn("rd_after_rst", 4'd0, 40'h100, 3'd3, 512'(0), 16'h0C2,
              {8{64'hDEADBEEFCAFEF00D}});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
